// File: rtl/clk_gen_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_multi_pkg
// Brief    : Shared types and helpers for the multi-channel tick generator.
// Revision : 1.0 - initial release
// ============================================================================
package clk_gen_multi_pkg;

    localparam int c_max_ch = 16;

    // What a channel does on the next edge; sync has highest priority.
    typedef enum logic [1:0] {
        CH_HOLD  = 2'd0,
        CH_COUNT = 2'd1,
        CH_WRAP  = 2'd2,
        CH_SYNC  = 2'd3
    } ch_op_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : clk_gen_multi_pkg
`default_nettype wire

// File: rtl/clk_gen_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_multi_ch
// Brief    : One divider channel: counter, active/pending divisor, tick and
//            square-wave registers with wrap-time divisor hand-over.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gen_multi_ch
    import clk_gen_multi_pkg::*;
#(
    parameter int          DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100000000
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_en,
    input  logic             in_sync,
    input  logic             in_wr,
    input  logic [DIV_W-1:0] in_wr_div,
    output logic             out_tick,
    output logic             out_sq
);

    localparam logic [DIV_W-1:0] c_default_div = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_one         = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_act_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_tick;
    logic             r_sq;

    ch_op_e           w_op;
    logic             w_last;
    logic [DIV_W-1:0] w_next_div;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_act_nxt;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             w_tick_nxt;
    logic             w_sq_nxt;

    always_comb begin
        w_last     = (r_cnt == (r_act_div - c_one));
        w_cnt_inc  = r_cnt + c_one;
        // A write landing on the wrap edge is taken straight into act_div.
        w_next_div = in_wr ? in_wr_div : r_pend_div;
        if (in_sync) begin
            w_op = CH_SYNC;
        end else if (!in_en) begin
            w_op = CH_HOLD;
        end else if (w_last) begin
            w_op = CH_WRAP;
        end else begin
            w_op = CH_COUNT;
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_act_nxt  = r_act_div;
        w_pend_nxt = w_next_div;
        w_tick_nxt = 1'b0;
        w_sq_nxt   = r_sq;
        case (w_op)
            CH_SYNC: begin
                w_cnt_nxt = '0;
                w_act_nxt = w_next_div;
                w_sq_nxt  = (w_next_div > c_one);
            end
            CH_WRAP: begin
                w_cnt_nxt  = '0;
                w_act_nxt  = w_next_div;
                w_tick_nxt = 1'b1;
                w_sq_nxt   = (w_next_div > c_one);
            end
            CH_COUNT: begin
                w_cnt_nxt = w_cnt_inc;
                w_sq_nxt  = (w_cnt_inc < (r_act_div >> 1));
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cnt      <= '0;
            r_act_div  <= c_default_div;
            r_pend_div <= c_default_div;
            r_tick     <= 1'b0;
            r_sq       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_act_div  <= w_act_nxt;
            r_pend_div <= w_pend_nxt;
            r_tick     <= w_tick_nxt;
            r_sq       <= w_sq_nxt;
        end
    end

    assign out_tick = r_tick;
    assign out_sq   = r_sq;

endmodule : clk_gen_multi_ch
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_multi
// Brief    : NUM_CH programmable tick / square-wave generators with validated
//            divisor writes and global enable / sync fan-out.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gen_multi
    import clk_gen_multi_pkg::*;
#(
    parameter int unsigned SOURCE_CLK  = 100000000,
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = SOURCE_CLK,
    parameter int          CH_W        = ch_width(NUM_CH)
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_en,
    input  logic              in_sync,
    input  logic              in_wr,
    input  logic [CH_W-1:0]   in_wr_ch,
    input  logic [DIV_W-1:0]  in_wr_div,
    output logic [NUM_CH-1:0] out_tick,
    output logic [NUM_CH-1:0] out_sq,
    output logic              out_wr_err
);

    localparam logic [CH_W:0] c_num_ch = (CH_W+1)'(NUM_CH);

    logic              w_ch_ok;
    logic              w_div_ok;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_ch_wr;
    logic              r_wr_err;

    generate
        if (SOURCE_CLK == 0 || DEFAULT_DIV == 0 || NUM_CH < 1 || NUM_CH > c_max_ch) begin : g_param_check
            $error("clk_gen_multi: illegal parameter combination");
        end
    endgenerate

    // Channel index is widened by one bit so the range test is exact for any NUM_CH.
    assign w_ch_ok  = ({1'b0, in_wr_ch} < c_num_ch);
    assign w_div_ok = |in_wr_div;
    assign w_wr_ok  = in_wr & w_ch_ok & w_div_ok;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= in_wr & ~w_wr_ok;
        end
    end

    assign out_wr_err = r_wr_err;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_ch_wr[i] = w_wr_ok && (in_wr_ch == CH_W'(i));

            clk_gen_multi_ch #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .in_clk    (in_clk),
                .in_rst_n  (in_rst_n),
                .in_en     (in_en),
                .in_sync   (in_sync),
                .in_wr     (w_ch_wr[i]),
                .in_wr_div (in_wr_div),
                .out_tick  (out_tick[i]),
                .out_sq    (out_sq[i])
            );
        end
    endgenerate

endmodule : clk_gen_multi
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen_multi
// Brief    : Directed table-driven bench for clk_gen_multi (3 channels, div 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gen_multi;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic              in_clk    = 1'b0;
    logic              in_rst_n  = 1'b0;
    logic              in_en     = 1'b0;
    logic              in_sync   = 1'b0;
    logic              in_wr     = 1'b0;
    logic [CH_W-1:0]   in_wr_ch  = '0;
    logic [DIV_W-1:0]  in_wr_div = '0;
    logic [NUM_CH-1:0] out_tick;
    logic [NUM_CH-1:0] out_sq;
    logic              out_wr_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          edge_n;
        logic        wr;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        chk_ts;
        logic [2:0]  tick;
        logic [2:0]  sq;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    clk_gen_multi #(
        .SOURCE_CLK  (10),
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (10)
    ) dut (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_en      (in_en),
        .in_sync    (in_sync),
        .in_wr      (in_wr),
        .in_wr_ch   (in_wr_ch),
        .in_wr_div  (in_wr_div),
        .out_tick   (out_tick),
        .out_sq     (out_sq),
        .out_wr_err (out_wr_err)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input int n, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // edge, wr, ch, div, chk_ts, tick{2,1,0}, sq{2,1,0}, err
        vecs.push_back('{ 1, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b111, 1'b0});
        vecs.push_back('{ 3, 1'b1, 2'd1, 16'd4, 1'b1, 3'b000, 3'b111, 1'b0});
        vecs.push_back('{ 4, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b111, 1'b0});
        vecs.push_back('{ 5, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b000, 1'b0});
        vecs.push_back('{ 9, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b000, 1'b0});
        vecs.push_back('{10, 1'b0, 2'd0, 16'd0, 1'b1, 3'b111, 3'b111, 1'b0});
        vecs.push_back('{12, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b101, 1'b0});
        vecs.push_back('{14, 1'b0, 2'd0, 16'd0, 1'b1, 3'b010, 3'b111, 1'b0});
        vecs.push_back('{15, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b010, 1'b0});
        vecs.push_back('{18, 1'b0, 2'd0, 16'd0, 1'b1, 3'b010, 3'b010, 1'b0});
        vecs.push_back('{20, 1'b1, 2'd2, 16'd6, 1'b1, 3'b101, 3'b101, 1'b0});
        vecs.push_back('{22, 1'b0, 2'd0, 16'd0, 1'b1, 3'b010, 3'b111, 1'b0});
        vecs.push_back('{23, 1'b0, 2'd0, 16'd0, 1'b1, 3'b000, 3'b011, 1'b0});
        vecs.push_back('{26, 1'b0, 2'd0, 16'd0, 1'b1, 3'b110, 3'b110, 1'b0});
        vecs.push_back('{30, 1'b0, 2'd0, 16'd0, 1'b1, 3'b011, 3'b011, 1'b0});
        vecs.push_back('{31, 1'b1, 2'd3, 16'd5, 1'b0, 3'b000, 3'b000, 1'b1});
        vecs.push_back('{32, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b0});
        vecs.push_back('{33, 1'b1, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b1});
        vecs.push_back('{34, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b0});
        vecs.push_back('{40, 1'b0, 2'd0, 16'd0, 1'b1, 3'b001, 3'b101, 1'b0});

        // Reset state
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_tick", 0, {13'b0, out_tick}, 16'h0);
        check("rst_sq",   0, {13'b0, out_sq},   16'h0);
        check("rst_err",  0, {15'b0, out_wr_err}, 16'h0);
        in_rst_n = 1'b1;
        in_en    = 1'b1;

        // Periods, deferred write on ch1, bypass write on ch2, invalid writes
        for (int n = 1; n <= 40; n++) begin
            in_wr = 1'b0;
            for (int k = 0; k < vecs.size(); k++) begin
                if (vecs[k].edge_n == n && vecs[k].wr) begin
                    in_wr     = 1'b1;
                    in_wr_ch  = vecs[k].ch;
                    in_wr_div = vecs[k].div;
                end
            end
            step();
            in_wr = 1'b0;
            for (int k = 0; k < vecs.size(); k++) begin
                if (vecs[k].edge_n == n) begin
                    if (vecs[k].chk_ts) begin
                        check("tbl_tick", n, {13'b0, out_tick}, {13'b0, vecs[k].tick});
                        check("tbl_sq",   n, {13'b0, out_sq},   {13'b0, vecs[k].sq});
                    end
                    check("tbl_err", n, {15'b0, out_wr_err}, {15'b0, vecs[k].err});
                end
            end
        end

        // Enable gap stretches the period; sync with enable low realigns
        in_rst_n = 1'b0;
        #2;
        in_rst_n = 1'b1;
        in_en    = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            in_en     = !((n >= 4 && n <= 10) || (n >= 29 && n <= 32));
            in_sync   = (n == 30);
            in_wr     = (n == 18) || (n == 44);
            in_wr_ch  = (n == 18) ? 2'd1 : 2'd0;
            in_wr_div = (n == 18) ? 16'd7 : 16'd3;
            step();
            in_wr   = 1'b0;
            in_sync = 1'b0;
            if (n <= 17)
                check("en_gap_tick", n, {13'b0, out_tick}, (n == 17) ? 16'h7 : 16'h0);
            if (n == 10)
                check("en_gap_sq", n, {13'b0, out_sq}, 16'h7);
            if (n == 27)
                check("wrap27_tick", n, {13'b0, out_tick}, 16'h7);
            if (n == 30) begin
                check("sync_tick", n, {13'b0, out_tick}, 16'h0);
                check("sync_sq",   n, {13'b0, out_sq},   16'h7);
            end
            if (n == 37 || n == 40)
                check("post_sync_quiet", n, {13'b0, out_tick}, 16'h0);
            if (n == 39)
                check("post_sync_ch1", n, {13'b0, out_tick}, 16'h2);
            if (n == 42)
                check("post_sync_ch02", n, {13'b0, out_tick}, 16'h5);
            if (n == 44)
                check("pre_rst_sq", n, {13'b0, out_sq}, 16'h5);
        end

        // Asynchronous reset between edges with a write pending on ch0
        #2;
        in_rst_n = 1'b0;
        #1;
        check("async_rst_tick", -1, {13'b0, out_tick}, 16'h0);
        check("async_rst_sq",   -1, {13'b0, out_sq},   16'h0);
        check("async_rst_err",  -1, {15'b0, out_wr_err}, 16'h0);
        #2;
        in_rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check("post_rst_tick", n, {13'b0, out_tick}, (n == 10) ? 16'h7 : 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_clk_gen_multi
`default_nettype wire
